// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared core constants for the interrupt controller
package irq_ctrl_pkg;

  // Width of the controller state register
  localparam int STATE_W = 2;

  // Controller states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  // Default service-routine address
  localparam logic [15:0] IRQ_VECTOR_DEFAULT = 16'h0010;

  // A latched request may be raised to the sequencer only when enabled, unmasked and not stalled
  function automatic logic req_allowed(input logic pending,
                                       input logic irq_en,
                                       input logic irq_mask,
                                       input logic stallb_en);
    return pending & irq_en & ~irq_mask & stallb_en;
  endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// rtl/irq_edge_latch.sv - rising-edge detector with pending and sticky overflow latch
module irq_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic interrupt,
  input  logic clr,
  input  logic ovf_clr,
  output logic pending,
  output logic ovf
);

  logic prev;
  logic edge_det;

  // prev resets to 0 so a line already high at reset release counts as an edge
  assign edge_det = interrupt & ~prev;

  // Remember the line level from the previous cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev <= 1'b0;
    end else begin
      prev <= interrupt;
    end
  end

  // A fresh edge wins over the clear, so an edge coinciding with acknowledge is kept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
    end else if (edge_det) begin
      pending <= 1'b1;
    end else if (clr) begin
      pending <= 1'b0;
    end
  end

  // Sticky overflow: an edge arriving while a request is still latched; set beats clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (edge_det && pending) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - single-level interrupt controller between external line and sequencer
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int                  PMA_SIZE   = 16,
  parameter logic [PMA_SIZE-1:0] IRQ_VECTOR = PMA_SIZE'(IRQ_VECTOR_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                interrupt,
  input  logic                irq_en,
  input  logic                irq_mask,
  input  logic                stallb_en,
  input  logic                ps_idle,
  input  logic                ps_irq_ack,
  input  logic                ps_rti,
  input  logic                ovf_clr,
  output logic                irq_req,
  output logic [PMA_SIZE-1:0] irq_vector,
  output logic                irq_active,
  output logic                irq_pending,
  output logic                irq_wake,
  output logic                irq_ovf
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic               pending;
  logic               ack_take;

  // Acknowledge only consumes the request while it is being presented
  assign ack_take = (state == ST_REQ) & ps_irq_ack;

  irq_edge_latch u_edge_latch (
    .clk       (clk),
    .reset     (reset),
    .interrupt (interrupt),
    .clr       (ack_take),
    .ovf_clr   (ovf_clr),
    .pending   (pending),
    .ovf       (irq_ovf)
  );

  // Next-state: once in REQ only the acknowledge moves us on; no nesting while in SERVICE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_allowed(pending, irq_en, irq_mask, stallb_en)) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ps_irq_ack) begin
          state_nxt = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (ps_rti) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign irq_req     = (state == ST_REQ);
  assign irq_vector  = irq_req ? IRQ_VECTOR : '0;
  assign irq_active  = (state == ST_SERVICE);
  assign irq_pending = pending;
  // Wake ignores the stall so an idling core can be roused before it resumes
  assign irq_wake    = ps_idle & pending & irq_en & ~irq_mask;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        interrupt = 1'b0;
  logic        irq_en = 1'b1;
  logic        irq_mask = 1'b0;
  logic        stallb_en = 1'b1;
  logic        ps_idle = 1'b0;
  logic        ps_irq_ack = 1'b0;
  logic        ps_rti = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        irq_req;
  logic [15:0] irq_vector;
  logic        irq_active;
  logic        irq_pending;
  logic        irq_wake;
  logic        irq_ovf;

  int n_pass = 0;
  int n_total = 0;

  irq_ctrl #(.PMA_SIZE(16), .IRQ_VECTOR(16'h0010)) dut (
    .clk         (clk),
    .reset       (reset),
    .interrupt   (interrupt),
    .irq_en      (irq_en),
    .irq_mask    (irq_mask),
    .stallb_en   (stallb_en),
    .ps_idle     (ps_idle),
    .ps_irq_ack  (ps_irq_ack),
    .ps_rti      (ps_rti),
    .ovf_clr     (ovf_clr),
    .irq_req     (irq_req),
    .irq_vector  (irq_vector),
    .irq_active  (irq_active),
    .irq_pending (irq_pending),
    .irq_wake    (irq_wake),
    .irq_ovf     (irq_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: a request is latched on each rising edge, waits for permission,
  // is offered until acknowledged, then is being serviced until return.
  bit m_prev, m_pending, m_ovf, m_offered, m_serving;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_prev <= 0; m_pending <= 0; m_ovf <= 0; m_offered <= 0; m_serving <= 0;
    end else begin
      m_prev <= interrupt;
      if (interrupt && !m_prev) m_pending <= 1;
      else if (m_offered && ps_irq_ack) m_pending <= 0;
      if (interrupt && !m_prev && m_pending) m_ovf <= 1;
      else if (ovf_clr) m_ovf <= 0;
      if (m_offered) begin
        m_offered <= !ps_irq_ack;
        m_serving <= ps_irq_ack;
      end else if (m_serving) begin
        m_serving <= !ps_rti;
      end else begin
        m_offered <= m_pending && irq_en && !irq_mask && stallb_en;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Advance to the next cycle, drive line/ack/rti, let combinational outputs settle
  task automatic cyc(input logic i, input logic a, input logic r);
    @(negedge clk);
    interrupt = i; ps_irq_ack = a; ps_rti = r;
    #1;
  endtask

  // Finish an offered request: acknowledge, return, then one idle cycle
  task automatic finish_irq();
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
  endtask

  typedef struct {
    logic        intr, ack, rti;
    logic        req, act, pend;
    logic [15:0] vec;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // Single pulse: edge in row 0, acknowledge in row 4, return in row 6
    tbl[0] = '{1, 0, 0, 0, 0, 0, 16'h0000};
    tbl[1] = '{1, 0, 0, 0, 0, 1, 16'h0000};
    tbl[2] = '{1, 0, 0, 1, 0, 1, 16'h0010};
    tbl[3] = '{1, 0, 0, 1, 0, 1, 16'h0010};
    tbl[4] = '{1, 1, 0, 1, 0, 1, 16'h0010};
    tbl[5] = '{0, 0, 0, 0, 1, 0, 16'h0000};
    tbl[6] = '{0, 0, 1, 0, 1, 0, 16'h0000};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 16'h0000};

    #2;
    chk("rst_req", irq_req, 0);
    chk("rst_vec", irq_vector, 0);
    chk("rst_act", irq_active, 0);
    chk("rst_pend", irq_pending, 0);
    chk("rst_ovf", irq_ovf, 0);
    chk("rst_wake", irq_wake, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    for (int k = 0; k < 8; k++) begin
      cyc(tbl[k].intr, tbl[k].ack, tbl[k].rti);
      chk($sformatf("tbl%0d_req", k), irq_req, tbl[k].req);
      chk($sformatf("tbl%0d_act", k), irq_active, tbl[k].act);
      chk($sformatf("tbl%0d_pend", k), irq_pending, tbl[k].pend);
      chk($sformatf("tbl%0d_vec", k), irq_vector, tbl[k].vec);
    end

    // Stall defers the request; it rises one cycle after stallb_en returns
    cyc(0, 0, 0); stallb_en = 0;
    cyc(1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0);
      chk("stall_req", irq_req, 0);
      chk("stall_pend", irq_pending, 1);
    end
    cyc(0, 0, 0); stallb_en = 1;
    chk("stall_rise_req", irq_req, 0);
    cyc(0, 0, 0);
    chk("stall_after_req", irq_req, 1);
    finish_irq();

    // Mask blocks request and wake but the edge is still latched
    irq_mask = 1; ps_idle = 1;
    cyc(1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0);
      chk("mask_req", irq_req, 0);
      chk("mask_wake", irq_wake, 0);
      chk("mask_pend", irq_pending, 1);
    end
    cyc(0, 0, 0); irq_mask = 0; #1;
    chk("unmask_wake", irq_wake, 1);
    cyc(0, 0, 0);
    chk("unmask_req", irq_req, 1);
    ps_idle = 0;
    finish_irq();

    // Back-to-back: edge during service waits for return
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("b2b_req", irq_req, 1);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("b2b_act", irq_active, 1);
    cyc(1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0);
      chk("b2b_svc_pend", irq_pending, 1);
      chk("b2b_svc_req", irq_req, 0);
    end
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("b2b_rti1_req", irq_req, 0);
    chk("b2b_rti1_act", irq_active, 0);
    cyc(0, 0, 0);
    chk("b2b_rti2_req", irq_req, 1);
    finish_irq();

    // Overflow: second edge with request still latched; set beats clear
    cyc(0, 0, 0); irq_en = 0;
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("ovf_first", irq_ovf, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("ovf_set", irq_ovf, 1);
    cyc(1, 0, 0); ovf_clr = 1;
    cyc(0, 0, 0); ovf_clr = 0;
    chk("ovf_clr_vs_edge", irq_ovf, 1);
    cyc(0, 0, 0); ovf_clr = 1;
    cyc(0, 0, 0); ovf_clr = 0;
    chk("ovf_cleared", irq_ovf, 0);
    irq_en = 1;
    cyc(0, 0, 0);
    chk("ovf_en_req", irq_req, 1);
    finish_irq();

    // Idle wake, then an edge coinciding with acknowledge is kept
    ps_idle = 1;
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("wake", irq_wake, 1);
    chk("wake_pend", irq_pending, 1);
    cyc(0, 0, 0);
    cyc(1, 1, 0);
    cyc(0, 0, 0);
    chk("ackedge_act", irq_active, 1);
    chk("ackedge_pend", irq_pending, 1);
    ps_idle = 0;
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("ackedge_req", irq_req, 1);
    finish_irq();
    cyc(0, 0, 0); ovf_clr = 1;
    cyc(0, 0, 0); ovf_clr = 0;

    // Reset mid-request drops everything; line held high re-triggers after release
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("rstreq_pre", irq_req, 1);
    #1 reset = 0;
    #1;
    chk("rstreq_req", irq_req, 0);
    chk("rstreq_pend", irq_pending, 0);
    chk("rstreq_act", irq_active, 0);
    chk("rstreq_vec", irq_vector, 0);
    #1 reset = 1;
    cyc(1, 0, 0);
    chk("rstrel_pend", irq_pending, 1);
    chk("rstrel_req", irq_req, 0);
    cyc(0, 0, 0);
    chk("rstrel_req2", irq_req, 1);
    finish_irq();

    // Randomized traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) interrupt = ~interrupt;
      ps_irq_ack = ($urandom_range(0, 3) == 0);
      ps_rti     = ($urandom_range(0, 4) == 0);
      irq_en     = ($urandom_range(0, 7) != 0);
      irq_mask   = ($urandom_range(0, 7) == 0);
      stallb_en  = ($urandom_range(0, 5) != 0);
      ps_idle    = 1'($urandom_range(0, 1));
      ovf_clr    = ($urandom_range(0, 9) == 0);
      #1;
      chk($sformatf("rnd%0d_req", n), irq_req, m_offered);
      chk($sformatf("rnd%0d_vec", n), irq_vector, m_offered ? 16'h0010 : 16'h0000);
      chk($sformatf("rnd%0d_act", n), irq_active, m_serving);
      chk($sformatf("rnd%0d_pend", n), irq_pending, m_pending);
      chk($sformatf("rnd%0d_ovf", n), irq_ovf, m_ovf);
      chk($sformatf("rnd%0d_wake", n), irq_wake, ps_idle & m_pending & irq_en & ~irq_mask);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
